// File: rtl/muldiv_unit_if.sv
// Bundle between control and the multiply/divide unit.
//
// Handshake: start is sampled only while busy=0. A start seen while busy=1 is
// dropped, never queued. busy rises at the accepting edge and falls at the
// completion edge. done is a one-cycle pulse in the cycle after completion;
// result and flags are valid then and hold until the next completion or reset.
interface muldiv_unit_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             div0;
  logic [1:0]       dbg_state;

  modport master (
    output start, op, a, b,
    input  busy, done, result, negative, zero, overflow, div0, dbg_state
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, negative, zero, overflow, div0, dbg_state
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: MUL, UMULH, UDIV, SDIV.
// One shift-add / shift-subtract step per clock; fixed WIDTH+1 edge latency.
module muldiv_unit #(
  parameter int WIDTH = 64
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_UMULH = 2'b01;
  localparam logic [1:0] OP_UDIV  = 2'b10;
  localparam logic [1:0] OP_SDIV  = 2'b11;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Control strobes from the output decoder
  logic load_en, step_en, fin_en, busy_o;

  // Datapath registers
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   opnd_q;   // multiplicand (MUL/UMULH) or divisor magnitude
  logic [2*WIDTH-1:0] acc_q;    // {hi, lo}: product, or {remainder, quotient}
  logic [CNT_W-1:0]   cnt_q;
  logic               qneg_q;   // SDIV quotient needs negation
  logic               sovf_q;   // SDIV most-negative / -1 seen at capture

  // Registered outputs
  logic [WIDTH-1:0] result_q, result_d;
  logic             neg_q, zero_q, ovf_q, ovf_d, div0_q, div0_d, done_q;

  // Capture-time operand conditioning
  logic [WIDTH-1:0]   abs_a, abs_b, init_opnd;
  logic [2*WIDTH-1:0] init_acc;
  logic               init_qneg, init_sovf;

  // Iteration step results
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_sub;
  logic               rem_ge;
  logic [2*WIDTH-1:0] div_next;
  logic               last_iter;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (last_iter) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output decode: busy and datapath strobes
  always_comb begin
    busy_o  = (state_q != S_IDLE);
    load_en = (state_q == S_IDLE) && bus.start;
    step_en = (state_q == S_RUN);
    fin_en  = (state_q == S_FIN);
  end

  // Operand setup: SDIV works on magnitudes, the sign is reapplied in FIN
  always_comb begin
    abs_a     = (bus.op == OP_SDIV && bus.a[WIDTH-1]) ? ('0 - bus.a) : bus.a;
    abs_b     = (bus.op == OP_SDIV && bus.b[WIDTH-1]) ? ('0 - bus.b) : bus.b;
    init_qneg = (bus.op == OP_SDIV) && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    init_sovf = (bus.op == OP_SDIV) && (bus.a == MIN_NEG) && (bus.b == '1);
    if (bus.op[1]) begin
      init_opnd = abs_b;
      init_acc  = {{WIDTH{1'b0}}, abs_a};
    end else begin
      init_opnd = bus.a;
      init_acc  = {{WIDTH{1'b0}}, bus.b};
    end
  end

  // One multiply step (LSB first) and one restoring-divide step (MSB first)
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    rem_sh    = acc_q[2*WIDTH-1:WIDTH-1];
    rem_ge    = (rem_sh >= {1'b0, opnd_q});
    rem_sub   = rem_sh[WIDTH-1:0] - opnd_q;
    div_next  = {(rem_ge ? rem_sub : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_ge};
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Result selection and flag generation for the completion edge
  always_comb begin
    result_d = '0;
    ovf_d    = 1'b0;
    div0_d   = 1'b0;
    case (op_q)
      OP_MUL: begin
        result_d = acc_q[WIDTH-1:0];
        ovf_d    = |acc_q[2*WIDTH-1:WIDTH];
      end
      OP_UMULH: result_d = acc_q[2*WIDTH-1:WIDTH];
      OP_UDIV: begin
        if (opnd_q == '0) div0_d   = 1'b1;
        else              result_d = acc_q[WIDTH-1:0];
      end
      OP_SDIV: begin
        if (opnd_q == '0) begin
          div0_d = 1'b1;
        end else begin
          result_d = qneg_q ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
          ovf_d    = sovf_q;
        end
      end
      default: result_d = '0;
    endcase
  end

  // Datapath: capture, iterate, register result on completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      sovf_q   <= 1'b0;
      result_q <= '0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      div0_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= fin_en;
      if (load_en) begin
        op_q   <= bus.op;
        opnd_q <= init_opnd;
        acc_q  <= init_acc;
        cnt_q  <= '0;
        qneg_q <= init_qneg;
        sovf_q <= init_sovf;
      end else if (step_en) begin
        acc_q <= op_q[1] ? div_next : mul_next;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (fin_en) begin
        result_q <= result_d;
        neg_q    <= result_d[WIDTH-1];
        zero_q   <= (result_d == '0);
        ovf_q    <= ovf_d;
        div0_q   <= div0_d;
      end
    end
  end

  assign bus.busy      = busy_o;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.negative  = neg_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.div0      = div0_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at WIDTH=64 and WIDTH=8.
module tb_muldiv_unit;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_UMULH = 2'b01;
  localparam logic [1:0] OP_UDIV  = 2'b10;
  localparam logic [1:0] OP_SDIV  = 2'b11;

  typedef struct {
    logic [63:0] res;
    logic        neg;
    logic        zero;
    logic        ovf;
    logic        dz;
    int          k;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errs = 0;

  exp_t exp_q64[$];
  exp_t exp_q8[$];
  exp_t e64, e8;

  muldiv_unit_if #(.WIDTH(64)) bus64 ();
  muldiv_unit_if #(.WIDTH(8))  bus8 ();

  muldiv_unit #(.WIDTH(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64));
  muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic exp_t model(input int w, input logic [1:0] op,
                                 input logic [63:0] a_in, input logic [63:0] b_in);
    exp_t        e;
    logic [63:0] mask, a, b, minv;
    logic [127:0] p;
    longint      sa, sb, q;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    minv = 64'd1 << (w - 1);
    a = a_in & mask;
    b = b_in & mask;
    e.res = '0; e.ovf = 1'b0; e.dz = 1'b0; e.k = 0;
    p = {64'd0, a} * {64'd0, b};
    case (op)
      OP_MUL: begin
        e.res = p[63:0] & mask;
        e.ovf = ((p >> w) != 128'd0);
      end
      OP_UMULH: e.res = 64'(p >> w) & mask;
      OP_UDIV: begin
        if (b == 0) e.dz = 1'b1;
        else        e.res = a / b;
      end
      default: begin
        if (b == 0) begin
          e.dz = 1'b1;
        end else if (a == minv && b == mask) begin
          e.res = a;
          e.ovf = 1'b1;
        end else begin
          sa = longint'(a << (64 - w)) >>> (64 - w);
          sb = longint'(b << (64 - w)) >>> (64 - w);
          q  = sa / sb;
          e.res = 64'(q) & mask;
        end
      end
    endcase
    e.neg  = e.res[w-1];
    e.zero = (e.res == 0);
    return e;
  endfunction

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (rst && bus64.done) begin
      if (exp_q64.size() == 0) begin
        check("w64_spurious_done", 64'd1, 64'd0);
      end else begin
        e64 = exp_q64.pop_front();
        check("w64_result", bus64.result, e64.res);
        check("w64_flags_nzvd", {bus64.negative, bus64.zero, bus64.overflow, bus64.div0},
              {e64.neg, e64.zero, e64.ovf, e64.dz});
        check("w64_latency", 64'(cyc - e64.k), 64'd65);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && bus8.done) begin
      if (exp_q8.size() == 0) begin
        check("w8_spurious_done", 64'd1, 64'd0);
      end else begin
        e8 = exp_q8.pop_front();
        check("w8_result", {56'd0, bus8.result}, e8.res);
        check("w8_flags_nzvd", {bus8.negative, bus8.zero, bus8.overflow, bus8.div0},
              {e8.neg, e8.zero, e8.ovf, e8.dz});
        check("w8_latency", 64'(cyc - e8.k), 64'd9);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; start is held for exactly one rising edge.
  task automatic issue(input int w, input logic [1:0] op, input logic [63:0] a,
                       input logic [63:0] b, input bit accept);
    exp_t e;
    e   = model(w, op, a, b);
    e.k = cyc + 1;
    if (w == 64) begin
      bus64.start = 1'b1; bus64.op = op; bus64.a = a; bus64.b = b;
      if (accept) exp_q64.push_back(e);
    end else begin
      bus8.start = 1'b1; bus8.op = op; bus8.a = a[7:0]; bus8.b = b[7:0];
      if (accept) exp_q8.push_back(e);
    end
    @(negedge clk);
    bus64.start = 1'b0;
    bus8.start  = 1'b0;
  endtask

  task automatic drain(input int w);
    int left;
    for (int i = 0; i < 300; i++) begin
      left = (w == 64) ? exp_q64.size() : exp_q8.size();
      if (left == 0) break;
      @(negedge clk);
    end
    left = (w == 64) ? exp_q64.size() : exp_q8.size();
    if (left != 0) begin
      check("drain_timeout", 64'(left), 64'd0);
      if (w == 64) exp_q64.delete();
      else         exp_q8.delete();
    end
  endtask

  task automatic wait_done64();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus64.done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("wait_done_timeout", 64'd0, 64'd1);
  endtask

  task automatic rand_ops(input int w, input int n);
    logic [1:0]  op;
    logic [63:0] a, b, minv;
    int          sel;
    minv = 64'd1 << (w - 1);
    for (int i = 0; i < n; i++) begin
      op  = 2'($urandom_range(0, 3));
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = 64'd0;
        1: b = 64'($urandom_range(1, 15));
        2: b = 64'hFFFF_FFFF_FFFF_FFFF;
        3: a = minv;
        4: a = 64'($urandom_range(0, 1000));
        default: ;
      endcase
      issue(w, op, a, b, 1'b1);
      drain(w);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus64.start = 1'b0; bus64.op = '0; bus64.a = '0; bus64.b = '0;
    bus8.start  = 1'b0; bus8.op  = '0; bus8.a  = '0; bus8.b  = '0;

    repeat (3) @(negedge clk);
    check("rst_busy",   {63'd0, bus64.busy}, 64'd0);
    check("rst_done",   {63'd0, bus64.done}, 64'd0);
    check("rst_result", bus64.result, 64'd0);
    check("rst_flags",  {bus64.negative, bus64.zero, bus64.overflow, bus64.div0}, 64'd0);
    check("rst_state",  {62'd0, bus64.dbg_state}, 64'd0);
    check("rst_w8_result", {56'd0, bus8.result}, 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // MUL 7*6 with busy window
    issue(64, OP_MUL, 64'd7, 64'd6, 1'b1);
    check("mul_busy_first", {63'd0, bus64.busy}, 64'd1);
    repeat (64) @(negedge clk);
    check("mul_busy_last", {63'd0, bus64.busy}, 64'd1);
    @(negedge clk);
    check("mul_busy_clear", {63'd0, bus64.busy}, 64'd0);
    drain(64);
    check("mul_7x6", bus64.result, 64'd42);

    issue(64, OP_UMULH, 64'h8000_0000_0000_0000, 64'd4, 1'b1);
    drain(64);
    check("umulh_const", bus64.result, 64'd2);
    issue(64, OP_MUL, 64'h8000_0000_0000_0000, 64'd4, 1'b1);
    drain(64);
    check("mul_ovf_const", {61'd0, bus64.zero, bus64.overflow, bus64.div0}, 64'b110);

    issue(64, OP_UDIV, 64'd100, 64'd7, 1'b1);
    drain(64);
    check("udiv_const", bus64.result, 64'd14);
    issue(64, OP_SDIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1);
    drain(64);
    check("sdiv_neg_const", bus64.result, 64'hFFFF_FFFF_FFFF_FFF2);

    issue(64, OP_UDIV, 64'd55, 64'd0, 1'b1);
    drain(64);
    check("div0_const", {60'd0, bus64.negative, bus64.zero, bus64.overflow, bus64.div0}, 64'b0101);
    issue(64, OP_SDIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    drain(64);
    check("sdiv_ovf_const", bus64.result, 64'h8000_0000_0000_0000);

    // start while busy is ignored
    issue(64, OP_MUL, 64'd123, 64'd456, 1'b1);
    repeat (9) @(negedge clk);
    issue(64, OP_MUL, 64'd9, 64'd9, 1'b0);
    drain(64);
    check("ignored_start", bus64.result, 64'd56088);

    // start in the done cycle is accepted
    issue(64, OP_UDIV, 64'd1000, 64'd10, 1'b1);
    wait_done64();
    issue(64, OP_MUL, 64'd11, 64'd13, 1'b1);
    drain(64);
    check("done_cycle_start", bus64.result, 64'd143);

    // reset mid-operation
    issue(64, OP_UDIV, 64'd1000, 64'd3, 1'b1);
    repeat (19) @(negedge clk);
    @(posedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy",   {63'd0, bus64.busy}, 64'd0);
    check("midrst_result", bus64.result, 64'd0);
    check("midrst_done",   {63'd0, bus64.done}, 64'd0);
    exp_q64.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (80) @(negedge clk);
    check("post_rst_idle", {63'd0, bus64.busy}, 64'd0);
    issue(64, OP_MUL, 64'd3, 64'd5, 1'b1);
    drain(64);
    check("post_rst_mul", bus64.result, 64'd15);

    // WIDTH=8 instance
    issue(8, OP_MUL, 64'd200, 64'd2, 1'b1);
    drain(8);
    check("w8_mul_const", {55'd0, bus8.overflow, bus8.result}, {55'd0, 1'b1, 8'd144});
    issue(8, OP_SDIV, 64'h80, 64'hFF, 1'b1);
    drain(8);
    check("w8_sdiv_ovf_const", {55'd0, bus8.overflow, bus8.result}, {55'd0, 1'b1, 8'h80});

    rand_ops(64, 40);
    rand_ops(8, 60);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
